// File: rtl/imm_rot_pkg.sv
// Shared widths, FSM state encoding and the imm8 fit test for the rotated-immediate encoder.
package imm_rot_pkg;

  localparam int unsigned ROT_W   = 4;
  localparam int unsigned IMM8_W  = 8;
  localparam int unsigned IMM12_W = 12;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

  // A rotated candidate is encodable when everything above imm8 is zero.
  function automatic logic check_fit(input logic [31:0] cand);
    return (cand[31:IMM8_W] == '0);
  endfunction

endpackage

// File: rtl/rol_even32.sv
// Combinational rotate-left of a 32-bit word by an even amount (2*i_rot).
module rol_even32
  import imm_rot_pkg::*;
(
  input  logic [31:0]      i_word,
  input  logic [ROT_W-1:0] i_rot,
  output logic [31:0]      o_word
);

  always_comb begin
    o_word = i_word;
    case (i_rot)
      4'd0:  o_word = i_word;
      4'd1:  o_word = {i_word[29:0], i_word[31:30]};
      4'd2:  o_word = {i_word[27:0], i_word[31:28]};
      4'd3:  o_word = {i_word[25:0], i_word[31:26]};
      4'd4:  o_word = {i_word[23:0], i_word[31:24]};
      4'd5:  o_word = {i_word[21:0], i_word[31:22]};
      4'd6:  o_word = {i_word[19:0], i_word[31:20]};
      4'd7:  o_word = {i_word[17:0], i_word[31:18]};
      4'd8:  o_word = {i_word[15:0], i_word[31:16]};
      4'd9:  o_word = {i_word[13:0], i_word[31:14]};
      4'd10: o_word = {i_word[11:0], i_word[31:12]};
      4'd11: o_word = {i_word[9:0],  i_word[31:10]};
      4'd12: o_word = {i_word[7:0],  i_word[31:8]};
      4'd13: o_word = {i_word[5:0],  i_word[31:6]};
      4'd14: o_word = {i_word[3:0],  i_word[31:4]};
      4'd15: o_word = {i_word[1:0],  i_word[31:2]};
    endcase
  end

endmodule

// File: rtl/imm_rot_encoder.sv
// Iterative encoder of a 32-bit constant into the ARM {rotate_imm, imm8} field, one rotation per clock.
// Optional IMM_ROT_INVERT_EN also searches ~value (MVN/BIC form) in the same cycle.
module imm_rot_encoder
  import imm_rot_pkg::*;
#(
  parameter int unsigned MAX_ROT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        value,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [IMM12_W-1:0] imm12,
  output logic               sh_carry,
  output logic               inverted
);

  state_t             r_state, w_state_nxt;
  logic [ROT_W-1:0]   r_rot, w_rot_nxt;
  logic [31:0]        r_val, w_val_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic               r_found, w_found_nxt;
  logic [IMM12_W-1:0] r_imm12, w_imm12_nxt;
  logic               r_sh_carry, w_sh_carry_nxt;
  logic [31:0]        w_cand;

  rol_even32 u_rol (
    .i_word (r_val),
    .i_rot  (r_rot),
    .o_word (w_cand)
  );

`ifdef IMM_ROT_INVERT_EN
  logic        r_inverted, w_inverted_nxt;
  logic [31:0] w_cand_inv;

  rol_even32 u_rol_inv (
    .i_word (~r_val),
    .i_rot  (r_rot),
    .o_word (w_cand_inv)
  );
`endif

  // Next-state and next-output logic; results hold outside accept/finish.
  always_comb begin
    w_state_nxt    = r_state;
    w_rot_nxt      = r_rot;
    w_val_nxt      = r_val;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_found_nxt    = r_found;
    w_imm12_nxt    = r_imm12;
    w_sh_carry_nxt = r_sh_carry;
`ifdef IMM_ROT_INVERT_EN
    w_inverted_nxt = r_inverted;
`endif
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt    = SEARCH;
          w_val_nxt      = value;
          w_rot_nxt      = '0;
          w_busy_nxt     = 1'b1;
          w_found_nxt    = 1'b0;
          w_imm12_nxt    = '0;
          w_sh_carry_nxt = 1'b0;
`ifdef IMM_ROT_INVERT_EN
          w_inverted_nxt = 1'b0;
`endif
        end
      end
      SEARCH: begin
        if (check_fit(w_cand)) begin
          w_state_nxt    = DONE;
          w_busy_nxt     = 1'b0;
          w_done_nxt     = 1'b1;
          w_found_nxt    = 1'b1;
          w_imm12_nxt    = {r_rot, w_cand[IMM8_W-1:0]};
          w_sh_carry_nxt = r_val[31];
`ifdef IMM_ROT_INVERT_EN
        end else if (check_fit(w_cand_inv)) begin
          w_state_nxt    = DONE;
          w_busy_nxt     = 1'b0;
          w_done_nxt     = 1'b1;
          w_found_nxt    = 1'b1;
          w_imm12_nxt    = {r_rot, w_cand_inv[IMM8_W-1:0]};
          w_sh_carry_nxt = ~r_val[31];
          w_inverted_nxt = 1'b1;
`endif
        end else if (r_rot == ROT_W'(MAX_ROT - 1)) begin
          w_state_nxt = DONE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_rot_nxt = r_rot + ROT_W'(1);
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rot      <= '0;
      r_val      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_found    <= 1'b0;
      r_imm12    <= '0;
      r_sh_carry <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rot      <= w_rot_nxt;
      r_val      <= w_val_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_found    <= w_found_nxt;
      r_imm12    <= w_imm12_nxt;
      r_sh_carry <= w_sh_carry_nxt;
    end
  end

`ifdef IMM_ROT_INVERT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inverted <= 1'b0;
    end else begin
      r_inverted <= w_inverted_nxt;
    end
  end

  assign inverted = r_inverted;
`else
  assign inverted = 1'b0;
`endif

  assign busy     = r_busy;
  assign done     = r_done;
  assign found    = r_found;
  assign imm12    = r_imm12;
  assign sh_carry = r_sh_carry;

endmodule

// File: tb/tb_imm_rot_encoder.sv
// Randomized and directed bench for imm_rot_encoder against a rotate-search reference model.
// Follows IMM_ROT_INVERT_EN the same way the design does.
module tb_imm_rot_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] value;
  logic        busy;
  logic        done;
  logic        found;
  logic [11:0] imm12;
  logic        sh_carry;
  logic        inverted;

  int n_checks = 0;
  int n_errors = 0;

  imm_rot_encoder #(.MAX_ROT(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .value    (value),
    .busy     (busy),
    .done     (done),
    .found    (found),
    .imm12    (imm12),
    .sh_carry (sh_carry),
    .inverted (inverted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    if (n == 0) return x;
    return (x << n) | (x >> (32 - n));
  endfunction

  // Reference: first even left-rotation that leaves the value below 256.
  task automatic model(input logic [31:0] v, output logic e_found, output logic [11:0] e_imm,
                       output logic e_sh, output logic e_inv, output int e_lat);
    logic [31:0] c;
    logic [31:0] ci;
    e_found = 1'b0;
    e_imm   = 12'h000;
    e_sh    = 1'b0;
    e_inv   = 1'b0;
    e_lat   = 17;
    for (int r = 0; r < 16; r++) begin
      c  = rol(v, 2 * r);
      ci = rol(~v, 2 * r);
      if (!e_found && c < 32'd256) begin
        e_found = 1'b1;
        e_imm   = {4'(r), c[7:0]};
        e_sh    = v[31];
        e_lat   = 2 + r;
      end
`ifdef IMM_ROT_INVERT_EN
      else if (!e_found && ci < 32'd256) begin
        e_found = 1'b1;
        e_inv   = 1'b1;
        e_imm   = {4'(r), ci[7:0]};
        e_sh    = ~v[31];
        e_lat   = 2 + r;
      end
`endif
    end
  endtask

  task automatic run_one(input logic [31:0] v);
    logic       e_found;
    logic [11:0] e_imm;
    logic       e_sh;
    logic       e_inv;
    int         e_lat;
    int         edges;
    model(v, e_found, e_imm, e_sh, e_inv, e_lat);
    start = 1'b1;
    value = v;
    step();
    start = 1'b0;
    value = $urandom;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("found_cleared", 32'(found), 32'd0);
    chk("imm12_cleared", 32'(imm12), 32'd0);
    edges = 0;
    while (!done && edges < 40) begin
      step();
      edges++;
    end
    chk("done_seen", 32'(done), 32'd1);
    chk("latency", 32'(edges + 1), 32'(e_lat));
    chk("found", 32'(found), 32'(e_found));
    chk("imm12", 32'(imm12), 32'(e_imm));
    chk("sh_carry", 32'(sh_carry), 32'(e_sh));
    chk("inverted", 32'(inverted), 32'(e_inv));
    chk("busy_at_done", 32'(busy), 32'd0);
    step();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("imm12_hold", 32'(imm12), 32'(e_imm));
    chk("found_hold", 32'(found), 32'(e_found));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_found"}, 32'(found), 32'd0);
    chk({tag, "_imm12"}, 32'(imm12), 32'd0);
    chk({tag, "_sh"}, 32'(sh_carry), 32'd0);
    chk({tag, "_inv"}, 32'(inverted), 32'd0);
  endtask

  logic [31:0] dir [8] = '{32'h0000_00FF, 32'hFF00_0000, 32'hF000_000F, 32'h0000_0102,
                           32'h0000_0000, 32'hFFFF_FF00, 32'h3FC0_0000, 32'h8000_0001};

  initial begin
    logic [31:0] imm8;
    int          r;
    reset = 1'b1;
    start = 1'b0;
    value = 32'h0;
    repeat (3) step();
    chk_all_zero("reset");
    reset = 1'b0;
    step();

    foreach (dir[i]) run_one(dir[i]);

    // Encodable by construction: imm8 rotated right by an even amount.
    for (int n = 0; n < 20; n++) begin
      imm8 = 32'($urandom_range(0, 255));
      r    = int'($urandom_range(0, 15));
      run_one(rol(imm8, (32 - 2 * r) % 32));
    end
    for (int n = 0; n < 15; n++) run_one($urandom);

    // Reset mid-search aborts it; the start pulse during SEARCH is not queued.
    start = 1'b1;
    value = 32'hFF00_0000;
    step();
    start = 1'b0;
    chk("abort_busy1", 32'(busy), 32'd1);
    step();
    start = 1'b1;
    value = 32'h0000_00FF;
    step();
    start = 1'b0;
    chk("ignored_start_busy", 32'(busy), 32'd1);
    chk("ignored_start_done", 32'(done), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_all_zero("abort");
    for (int n = 0; n < 8; n++) begin
      step();
      chk("no_done_after_abort", 32'(done), 32'd0);
      chk("idle_after_abort", 32'(busy), 32'd0);
    end
    run_one(32'h0000_00FF);

    // Start coincident with reset is ignored.
    reset = 1'b1;
    start = 1'b1;
    value = 32'h0000_00FF;
    step();
    reset = 1'b0;
    start = 1'b0;
    chk("start_with_reset_busy", 32'(busy), 32'd0);
    step();
    chk("start_with_reset_busy2", 32'(busy), 32'd0);
    chk("start_with_reset_done", 32'(done), 32'd0);
    step();
    chk("start_with_reset_done2", 32'(done), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
